// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - requester-side bus bundle for ram_port_arbiter (m_lock present only with MEM_ARB_LOCK_EN)
interface ram_port_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]            m_req;
    logic [NUM_REQ-1:0]            m_we;
    logic [NUM_REQ*ADDR_W-1:0]     m_addr;
    logic [NUM_REQ*DATA_W-1:0]     m_wdata;
    logic [NUM_REQ*DATA_W/8-1:0]   m_wmask;
`ifdef MEM_ARB_LOCK_EN
    logic [NUM_REQ-1:0]            m_lock;
`endif
    logic [NUM_REQ-1:0]            m_gnt;
    logic [NUM_REQ-1:0]            m_rvalid;
    logic [DATA_W-1:0]             m_rdata;

    modport master (
`ifdef MEM_ARB_LOCK_EN
        output m_lock,
`endif
        output m_req, m_we, m_addr, m_wdata, m_wmask,
        input  m_gnt, m_rvalid, m_rdata
    );

    modport slave (
`ifdef MEM_ARB_LOCK_EN
        input  m_lock,
`endif
        input  m_req, m_we, m_addr, m_wdata, m_wmask,
        output m_gnt, m_rvalid, m_rdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin arbiter sharing one single-port RAM; MEM_ARB_LOCK_EN adds locked ownership
module ram_port_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32
) (
    input  logic                  usb_clk_60m,
    input  logic                  sys_rst_n,
    ram_port_arbiter_if.slave     bus,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    output logic [DATA_W/8-1:0]   ram_wmask,
    input  logic [DATA_W-1:0]     ram_rdata
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int MSK_W = DATA_W / 8;

    logic [IDX_W-1:0]   r_ptr;
    logic               r_rd_vld;
    logic [IDX_W-1:0]   r_rd_tag;

    logic [NUM_REQ-1:0] w_req_eff;
    logic [NUM_REQ-1:0] w_gnt;
    logic               w_gnt_any;
    logic [IDX_W-1:0]   w_win_idx;
    logic [IDX_W-1:0]   w_scan;
    logic [IDX_W-1:0]   w_ptr_next;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
        return (v == IDX_W'(NUM_REQ - 1)) ? '0 : v + IDX_W'(1);
    endfunction

`ifdef MEM_ARB_LOCK_EN
    logic               r_own_vld;
    logic [IDX_W-1:0]   r_own_idx;

    // while a requester owns the RAM, every other request is masked out
    always_comb begin
        w_req_eff = bus.m_req;
        if (r_own_vld) begin
            w_req_eff = bus.m_req & (NUM_REQ'(1) << r_own_idx);
        end
    end
`else
    // no locking: every request competes
    always_comb begin
        w_req_eff = bus.m_req;
    end
`endif

    // scan from the pointer and grant the first requester found; nothing is granted in reset
    always_comb begin
        w_gnt     = '0;
        w_gnt_any = 1'b0;
        w_win_idx = '0;
        w_scan    = r_ptr;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_gnt_any && sys_rst_n && w_req_eff[w_scan]) begin
                w_gnt_any = 1'b1;
                w_win_idx = w_scan;
            end
            w_scan = wrap_inc(w_scan);
        end
        if (w_gnt_any) begin
            w_gnt[w_win_idx] = 1'b1;
        end
        w_ptr_next = wrap_inc(w_win_idx);
    end

    assign bus.m_gnt = w_gnt;

    // steer the winner's access onto the RAM port
    always_comb begin
        ram_en    = w_gnt_any;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_wmask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                ram_we    = bus.m_we[i];
                ram_addr  = bus.m_addr[i*ADDR_W +: ADDR_W];
                ram_wdata = bus.m_wdata[i*DATA_W +: DATA_W];
                ram_wmask = bus.m_wmask[i*MSK_W +: MSK_W];
            end
        end
    end

    // advance the round-robin pointer past each winner (and track lock ownership when enabled)
    always_ff @(posedge usb_clk_60m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_ptr     <= '0;
`ifdef MEM_ARB_LOCK_EN
            r_own_vld <= 1'b0;
            r_own_idx <= '0;
`endif
        end else begin
`ifdef MEM_ARB_LOCK_EN
            if (r_own_vld && !bus.m_req[r_own_idx]) begin
                r_own_vld <= 1'b0;
                r_ptr     <= wrap_inc(r_own_idx);
            end else if (w_gnt_any) begin
                r_ptr     <= w_ptr_next;
                r_own_vld <= bus.m_lock[w_win_idx];
                r_own_idx <= w_win_idx;
            end
`else
            if (w_gnt_any) begin
                r_ptr <= w_ptr_next;
            end
`endif
        end
    end

    // remember which requester issued a read so its data can be tagged next cycle
    always_ff @(posedge usb_clk_60m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rd_vld <= 1'b0;
            r_rd_tag <= '0;
        end else begin
            r_rd_vld <= w_gnt_any && !ram_we;
            r_rd_tag <= w_win_idx;
        end
    end

    // decode the read tag into the per-requester valid strobe
    always_comb begin
        bus.m_rvalid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.m_rvalid[i] = r_rd_vld && (r_rd_tag == IDX_W'(i));
        end
    end

    assign bus.m_rdata = ram_rdata;

endmodule
